// File: rtl/ctrl_pkg.sv
// Shared definitions for the control unit: FSM state type, opcode and condition-code values,
// PC source encodings and flag bit positions. The IRQ state exists only with CTRL_IRQ_EN.
package ctrl_pkg;

`ifdef CTRL_IRQ_EN
    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, IRQ} state_t;
`else
    typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_t;
`endif

    localparam logic [3:0] OP_ADC = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0011;
    localparam logic [3:0] OP_LDW = 4'b1010;
    localparam logic [3:0] OP_STW = 4'b1011;
    localparam logic [3:0] OP_BCC = 4'b1100;
    localparam logic [3:0] OP_BL  = 4'b1101;
    localparam logic [3:0] OP_RET = 4'b1110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BUS = 2'b01;
    localparam logic [1:0] PC_REL = 2'b10;
    localparam logic [1:0] PC_VEC = 2'b11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Opcodes 0000-1001 are ALU operations; 1000/1001 take the immediate operand.
    function automatic logic isAluOp(input logic [3:0] op);
        return (op[3] == 1'b0) || (op[3:1] == 3'b100);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: decodes the 4-bit condition field against {V,C,N,Z}.
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic z, n, c, v;

    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ: taken = z;
            CC_NE: taken = !z;
            CC_CS: taken = c;
            CC_CC: taken = !c;
            CC_MI: taken = n;
            CC_PL: taken = !n;
            CC_VS: taken = v;
            CC_VC: taken = !v;
            CC_HI: taken = c && !z;
            CC_LS: taken = !c || z;
            CC_GE: taken = (n == v);
            CC_LT: taken = (n != v);
            CC_GT: taken = !z && (n == v);
            CC_LE: taken = z || (n != v);
            CC_AL: taken = 1'b1;
            CC_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH -> EXEC [-> MEM] -> FETCH, outputs decoded from state and Ir.
// Interrupt entry (Irq port and IRQ state) is compiled in only when CTRL_IRQ_EN is defined.
module control_unit
    import ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        nReset,
    input  logic [15:0] Ir,
    input  logic [3:0]  Flags,
    input  logic        MemReady,
`ifdef CTRL_IRQ_EN
    input  logic        Irq,
`endif
    output logic        IrWe,
    output logic        PcWe,
    output logic        PcEn,
    output logic [1:0]  PcSel,
    output logic        LrWe,
    output logic        LrEn,
    output logic        LrSel,
    output logic        RegWe,
    output logic        WdSel,
    output logic [1:0]  RwSel,
    output logic [1:0]  Rs1Sel,
    output logic        AluWe,
    output logic        AluEn,
    output logic        ImmSel,
    output logic        Op1Sel,
    output logic        Op2Sel,
    output logic        CFlag,
    output logic        MemEn,
    output logic        nME,
    output logic        RnW
);

    state_t     state;
    state_t     retState;
    logic [3:0] op;
    logic       taken;
    logic       isMemOp;
    logic       unusedIrBits;

    assign op           = Ir[15:12];
    assign isMemOp      = (op == OP_LDW) || (op == OP_STW);
    assign unusedIrBits = ^Ir[7:0];

    cond_eval uCondEval (
        .cond  (Ir[11:8]),
        .flags (Flags),
        .taken (taken)
    );

    // Irq is only looked at on the way back to FETCH, so it never splits an instruction.
`ifdef CTRL_IRQ_EN
    assign retState = Irq ? IRQ : FETCH;
`else
    assign retState = FETCH;
`endif

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (MemReady) state <= EXEC;
                EXEC:    state <= isMemOp ? MEM : retState;
                MEM:     if (MemReady) state <= retState;
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs are forced idle while nReset is low so no write fires in the reset cycle.
    always_comb begin
        IrWe   = 1'b0;
        PcWe   = 1'b0;
        PcEn   = 1'b0;
        PcSel  = PC_INC;
        LrWe   = 1'b0;
        LrEn   = 1'b0;
        LrSel  = 1'b0;
        RegWe  = 1'b0;
        WdSel  = 1'b0;
        RwSel  = 2'b00;
        Rs1Sel = 2'b00;
        AluWe  = 1'b0;
        AluEn  = 1'b0;
        ImmSel = 1'b0;
        Op1Sel = 1'b0;
        Op2Sel = 1'b0;
        CFlag  = 1'b0;
        MemEn  = 1'b0;
        nME    = 1'b1;
        RnW    = 1'b1;
        if (nReset) begin
            CFlag = ((op == OP_ADC) || (op == OP_SBC)) && Flags[FLAG_C];
            case (state)
                FETCH: begin
                    nME   = 1'b0;
                    MemEn = 1'b1;
                    IrWe  = MemReady;
                    PcWe  = MemReady;
                end
                EXEC: begin
                    if (isAluOp(op)) begin
                        AluWe  = 1'b1;
                        AluEn  = 1'b1;
                        RegWe  = 1'b1;
                        RwSel  = 2'b01;
                        Rs1Sel = 2'b01;
                        ImmSel = op[3];
                        Op2Sel = op[3];
                    end else begin
                        case (op)
                            OP_LDW, OP_STW: begin
                                AluWe  = 1'b1;
                                ImmSel = 1'b1;
                                Op2Sel = 1'b1;
                                Rs1Sel = 2'b01;
                            end
                            OP_BCC: begin
                                PcSel = PC_REL;
                                PcWe  = taken;
                            end
                            OP_BL: begin
                                LrWe  = 1'b1;
                                PcSel = PC_REL;
                                PcWe  = 1'b1;
                            end
                            OP_RET: begin
                                LrEn  = 1'b1;
                                PcSel = PC_BUS;
                                PcWe  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MEM: begin
                    if (op == OP_LDW) begin
                        nME   = 1'b0;
                        MemEn = 1'b1;
                        RegWe = MemReady;
                        WdSel = 1'b1;
                        RwSel = 2'b01;
                    end else if (op == OP_STW) begin
                        nME   = 1'b0;
                        RnW   = 1'b0;
                        AluEn = 1'b1;
                    end
                end
`ifdef CTRL_IRQ_EN
                IRQ: begin
                    LrWe  = 1'b1;
                    PcSel = PC_VEC;
                    PcWe  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random instruction streams,
// checked cycle by cycle against an instruction-level reference model.
`timescale 1ns/1ps
module tb_control_unit;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        nReset;
    logic [15:0] Ir;
    logic [3:0]  Flags;
    logic        MemReady;
    logic        Irq;
    logic        IrWe, PcWe, PcEn, LrWe, LrEn, LrSel, RegWe, WdSel;
    logic [1:0]  PcSel, RwSel, Rs1Sel;
    logic        AluWe, AluEn, ImmSel, Op1Sel, Op2Sel, CFlag, MemEn, nME, RnW;

    int errors = 0;
    int checks = 0;
    int regWePulses = 0;
    logic [15:0] lastIr = 16'hF000;

`ifdef CTRL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
    logic unusedIrq;
    assign unusedIrq = Irq;
`endif

    typedef struct packed {
        logic irWe, pcWe, pcEn;
        logic [1:0] pcSel;
        logic lrWe, lrEn, lrSel, regWe, wdSel;
        logic [1:0] rwSel, rs1Sel;
        logic aluWe, aluEn, immSel, op1Sel, op2Sel, cFlag, memEn, nME, rnW;
    } out_t;

    out_t obs;
    assign obs = {IrWe, PcWe, PcEn, PcSel, LrWe, LrEn, LrSel, RegWe, WdSel, RwSel, Rs1Sel,
                  AluWe, AluEn, ImmSel, Op1Sel, Op2Sel, CFlag, MemEn, nME, RnW};

    control_unit dut (
        .Clock(Clock), .nReset(nReset), .Ir(Ir), .Flags(Flags), .MemReady(MemReady),
`ifdef CTRL_IRQ_EN
        .Irq(Irq),
`endif
        .IrWe(IrWe), .PcWe(PcWe), .PcEn(PcEn), .PcSel(PcSel), .LrWe(LrWe), .LrEn(LrEn),
        .LrSel(LrSel), .RegWe(RegWe), .WdSel(WdSel), .RwSel(RwSel), .Rs1Sel(Rs1Sel),
        .AluWe(AluWe), .AluEn(AluEn), .ImmSel(ImmSel), .Op1Sel(Op1Sel), .Op2Sel(Op2Sel),
        .CFlag(CFlag), .MemEn(MemEn), .nME(nME), .RnW(RnW)
    );

    // ---------------- reference model ----------------
    function automatic out_t quiet();
        out_t o;
        o = '0;
        o.nME = 1'b1;
        o.rnW = 1'b1;
        return o;
    endfunction

    function automatic logic carryIn(input logic [15:0] ir, input logic [3:0] fl);
        return (ir[15:12] == 4'd2 || ir[15:12] == 4'd3) ? fl[2] : 1'b0;
    endfunction

    // Conditions come in complementary pairs: even code = base test, odd code = its inverse.
    function automatic logic branchTaken(input logic [3:0] cc, input logic [3:0] fl);
        logic z, n, c, v, base;
        z = fl[0]; n = fl[1]; c = fl[2]; v = fl[3];
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    function automatic out_t expFetch(input logic mr, input logic [15:0] ir, input logic [3:0] fl);
        out_t o;
        o = quiet();
        o.nME = 1'b0; o.memEn = 1'b1; o.irWe = mr; o.pcWe = mr;
        o.cFlag = carryIn(ir, fl);
        return o;
    endfunction

    function automatic out_t expExec(input logic [15:0] ir, input logic [3:0] fl);
        out_t o;
        int op;
        o = quiet();
        o.cFlag = carryIn(ir, fl);
        op = int'(ir[15:12]);
        if (op <= 9) begin
            o.aluWe = 1'b1; o.aluEn = 1'b1; o.regWe = 1'b1; o.rwSel = 2'd1; o.rs1Sel = 2'd1;
            o.immSel = (op >= 8); o.op2Sel = (op >= 8);
        end else if (op == 10 || op == 11) begin
            o.aluWe = 1'b1; o.immSel = 1'b1; o.op2Sel = 1'b1; o.rs1Sel = 2'd1;
        end else if (op == 12) begin
            o.pcSel = 2'd2; o.pcWe = branchTaken(ir[11:8], fl);
        end else if (op == 13) begin
            o.lrWe = 1'b1; o.pcSel = 2'd2; o.pcWe = 1'b1;
        end else if (op == 14) begin
            o.lrEn = 1'b1; o.pcSel = 2'd1; o.pcWe = 1'b1;
        end
        return o;
    endfunction

    function automatic out_t expMem(input logic [15:0] ir, input logic mr, input logic [3:0] fl);
        out_t o;
        o = quiet();
        o.cFlag = carryIn(ir, fl);
        o.nME = 1'b0;
        if (ir[15:12] == 4'd10) begin
            o.memEn = 1'b1; o.regWe = mr; o.wdSel = 1'b1; o.rwSel = 2'd1;
        end else begin
            o.rnW = 1'b0; o.aluEn = 1'b1;
        end
        return o;
    endfunction

    function automatic out_t expIrq(input logic [15:0] ir, input logic [3:0] fl);
        out_t o;
        o = quiet();
        o.cFlag = carryIn(ir, fl);
        o.lrWe = 1'b1; o.pcSel = 2'd3; o.pcWe = 1'b1;
        return o;
    endfunction

    // ---------------- checking and driving ----------------
    task automatic check(input string tag, input out_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        checks++;
        assert ($countones({PcEn, LrEn, AluEn, MemEn}) <= 1) else begin
            errors++;
            $error("FAIL %s_busExcl observed=%b expected=at most one set", tag, {PcEn, LrEn, AluEn, MemEn});
        end
    endtask

    task automatic checkInt(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic cyc(input string tag, input logic rstN, input logic [15:0] ir, input logic [3:0] fl,
                       input logic mr, input logic irq, input out_t exp);
        @(negedge Clock);
        nReset = rstN; Ir = ir; Flags = fl; MemReady = mr; Irq = irq;
        #1;
        check(tag, exp);
        if (RegWe === 1'b1) regWePulses++;
    endtask

    // One whole instruction: fw fetch waits, exec, and mw memory waits for loads/stores.
    // exFl[4]=1 picks random exec flags, otherwise exFl[3:0] is used.
    task automatic runInstr(input string name, input logic [15:0] ir, input int fw, input int mw,
                            input logic irqEnd, input logic [4:0] exFl);
        logic [3:0] fl;
        logic isMem, endIrq;
        endIrq = irqEnd & IRQ_EN;
        isMem = (ir[15:13] == 3'b101);
        for (int i = 0; i < fw; i++) begin
            fl = 4'($urandom);
            cyc({name, "_fwait"}, 1'b1, lastIr, fl, 1'b0, 1'($urandom), expFetch(1'b0, lastIr, fl));
        end
        fl = 4'($urandom);
        cyc({name, "_fetch"}, 1'b1, lastIr, fl, 1'b1, 1'($urandom), expFetch(1'b1, lastIr, fl));
        fl = exFl[4] ? 4'($urandom) : exFl[3:0];
        cyc({name, "_exec"}, 1'b1, ir, fl, 1'($urandom), isMem ? 1'($urandom) : endIrq, expExec(ir, fl));
        if (isMem) begin
            for (int i = 0; i < mw; i++) begin
                fl = 4'($urandom);
                cyc({name, "_mwait"}, 1'b1, ir, fl, 1'b0, 1'($urandom), expMem(ir, 1'b0, fl));
            end
            fl = 4'($urandom);
            cyc({name, "_mem"}, 1'b1, ir, fl, 1'b1, endIrq, expMem(ir, 1'b1, fl));
        end
        if (endIrq) begin
            fl = 4'($urandom);
            cyc({name, "_irq"}, 1'b1, ir, fl, 1'($urandom), 1'($urandom), expIrq(ir, fl));
        end
        lastIr = ir;
    endtask

    initial begin
        logic [3:0] fl;
        logic [15:0] rir;
        nReset = 1'b0; Ir = 16'hF000; Flags = 4'h0; MemReady = 1'b1; Irq = 1'b0;

        // Reset: idle outputs even with MemReady high.
        for (int i = 0; i < 2; i++) begin
            fl = 4'($urandom);
            cyc("reset", 1'b0, 16'h2000, fl, 1'b1, 1'b0, quiet());
        end

        // Two-cycle ALU register op, then back in FETCH.
        runInstr("alu_reg", 16'h0123, 0, 0, 1'b0, 5'h10);
        runInstr("alu_imm", 16'h8456, 1, 0, 1'b0, 5'h10);
        runInstr("adc_c1", 16'h2345, 0, 0, 1'b0, 5'h04);
        runInstr("sbc_c0", 16'h3345, 0, 0, 1'b0, 5'h0B);

        // Branch EQ taken / not taken, and BL / RET / NOP.
        runInstr("beq_taken", 16'hC010, 0, 0, 1'b0, 5'h01);
        runInstr("beq_not", 16'hC010, 0, 0, 1'b0, 5'h0E);
        runInstr("bl", 16'hD004, 0, 0, 1'b0, 5'h10);
        runInstr("ret", 16'hE000, 2, 0, 1'b0, 5'h10);
        runInstr("nop", 16'hF000, 0, 0, 1'b0, 5'h10);

        // Load with four wait cycles: exactly one RegWe pulse.
        regWePulses = 0;
        runInstr("ldw_wait", 16'hA120, 0, 4, 1'b0, 5'h10);
        checkInt("ldw_regwe_pulses", regWePulses, 1);
        runInstr("stw_wait", 16'hB340, 1, 2, 1'b0, 5'h10);

        // Reset held three cycles while a load waits in MEM.
        fl = 4'($urandom);
        cyc("rstmem_fetch", 1'b1, lastIr, fl, 1'b1, 1'b0, expFetch(1'b1, lastIr, fl));
        fl = 4'($urandom);
        cyc("rstmem_exec", 1'b1, 16'hA555, fl, 1'b0, 1'b0, expExec(16'hA555, fl));
        fl = 4'($urandom);
        cyc("rstmem_mwait", 1'b1, 16'hA555, fl, 1'b0, 1'b0, expMem(16'hA555, 1'b0, fl));
        regWePulses = 0;
        for (int i = 0; i < 3; i++) begin
            fl = 4'($urandom);
            cyc("rstmem_reset", 1'b0, 16'hA555, fl, 1'b0, 1'b0, quiet());
        end
        fl = 4'($urandom);
        cyc("rstmem_release", 1'b1, 16'hA555, fl, 1'b0, 1'b0, expFetch(1'b0, 16'hA555, fl));
        checkInt("rstmem_regwe_pulses", regWePulses, 0);
        lastIr = 16'hA555;

        // Interrupt after a load completes, and after a branch.
        if (IRQ_EN) begin
            runInstr("irq_ldw", 16'hA123, 0, 2, 1'b1, 5'h10);
            runInstr("irq_bcc", 16'hC210, 1, 0, 1'b1, 5'h10);
            runInstr("after_irq", 16'h1111, 0, 0, 1'b0, 5'h10);
        end

        // Random instruction stream.
        for (int k = 0; k < 150; k++) begin
            rir = 16'($urandom);
            runInstr("rand", rir, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     1'($urandom), 5'h10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
